// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FP32 multiplier between
// NUM_REQ requesters. One operation in flight; results return on a one-hot
// strobe with a shared data bus; a watchdog answers with ERR_NAN and
// resp_err if the multiplier never completes.
//
// Handshake: a requester holds req_valid and its operands until it sees its
// req_accept bit (one-cycle pulse); req_valid still high in the following
// cycle is a new request. resp_valid is a one-cycle pulse with no
// backpressure. mul_valid is a one-cycle issue pulse, and mul_ready a
// one-cycle completion pulse that is honoured only while waiting.
//
// Timing: mul_valid and req_accept rise in the ISSUE cycle. mul_ready is
// seen in WAIT_RES, the result is latched, RESPOND loads the registered
// response outputs, so resp_valid is visible two cycles after mul_ready.
// A timeout fires in the WAIT_RES cycle where timer == TIMEOUT_CYCLES-1,
// which puts resp_valid TIMEOUT_CYCLES+2 cycles after the ISSUE cycle.
module fpu_mul_arbiter #(
    parameter int          NUM_REQ        = 4,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_NAN        = 32'h7FC00000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_accept,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [31:0]             resp_data,
    output logic                    resp_err,
    output logic [31:0]             mul_din1,
    output logic [31:0]             mul_din2,
    output logic                    mul_valid,
    input  logic [31:0]             mul_result,
    input  logic                    mul_ready,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [NUM_REQ-1:0] ONE     = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0]    LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0]   TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2,
        RESPOND  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [31:0]        res_q, res_d;
    logic               err_q, err_d;
    logic [NUM_REQ-1:0] req_accept_q, req_accept_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [31:0]        resp_data_q, resp_data_d;
    logic               resp_err_q, resp_err_d;
    logic [31:0]        mul_din1_q, mul_din1_d;
    logic [31:0]        mul_din2_q, mul_din2_d;
    logic               mul_valid_q, mul_valid_d;
    logic               busy_q, busy_d;

    logic               grant_found;
    logic [ID_W-1:0]    grant_id;

    // Round-robin search: first requesting index at or above ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    // Next-state and registered-output logic; pulses default low each cycle.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        timer_d      = timer_q;
        res_d        = res_q;
        err_d        = err_q;
        req_accept_d = '0;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        resp_err_d   = 1'b0;
        mul_din1_d   = mul_din1_q;
        mul_din2_d   = mul_din2_q;
        mul_valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    id_d         = grant_id;
                    mul_din1_d   = req_a[32*grant_id +: 32];
                    mul_din2_d   = req_b[32*grant_id +: 32];
                    req_accept_d = ONE << grant_id;
                    mul_valid_d  = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT_RES;
            end
            WAIT_RES: begin
                // A completion in the timeout cycle still counts as a result.
                if (mul_ready) begin
                    res_d   = mul_result;
                    err_d   = 1'b0;
                    state_d = RESPOND;
                end else if (timer_q == TMR_MAX) begin
                    res_d   = ERR_NAN;
                    err_d   = 1'b1;
                    state_d = RESPOND;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESPOND: begin
                resp_valid_d = ONE << id_q;
                resp_data_d  = res_q;
                resp_err_d   = err_q;
                ptr_d        = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            timer_q      <= '0;
            res_q        <= '0;
            err_q        <= 1'b0;
            req_accept_q <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            mul_din1_q   <= '0;
            mul_din2_q   <= '0;
            mul_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            timer_q      <= timer_d;
            res_q        <= res_d;
            err_q        <= err_d;
            req_accept_q <= req_accept_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            mul_din1_q   <= mul_din1_d;
            mul_din2_q   <= mul_din2_d;
            mul_valid_q  <= mul_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign req_accept = req_accept_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign mul_din1   = mul_din1_q;
    assign mul_din2   = mul_din2_q;
    assign mul_valid  = mul_valid_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Bench for fpu_mul_arbiter: behavioural multiplier stub, table of
// single-requester transactions, and hand-written arbitration, timeout,
// ready/timeout tie and mid-operation reset sequences.
module tb_fpu_mul_arbiter;
  localparam int NR   = 4;
  localparam int TOUT = 16;
  localparam logic [31:0] NAN = 32'h7FC00000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*32-1:0]  req_a = '0;
  logic [NR*32-1:0]  req_b = '0;
  logic [NR-1:0]     req_accept;
  logic [NR-1:0]     resp_valid;
  logic [31:0]       resp_data;
  logic              resp_err;
  logic [31:0]       mul_din1;
  logic [31:0]       mul_din2;
  logic              mul_valid;
  logic [31:0]       mul_result;
  logic              mul_ready;
  logic              busy;
  logic [1:0]        dbg_state;

  fpu_mul_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TOUT), .ERR_NAN(NAN)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_accept(req_accept), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .mul_din1(mul_din1), .mul_din2(mul_din2),
    .mul_valid(mul_valid), .mul_result(mul_result), .mul_ready(mul_ready),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int unexp_cnt = 0;
  int resp_cyc = 0;
  int issue_cyc = 0;

  // scoreboards: response {err, id[2:0], data}, accept {onehot, a, b}
  logic [35:0] exp_q[$];
  logic [67:0] acc_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // normal-number FP32 multiply (truncating); enough for exact products
  function automatic logic [31:0] fp_mul_model(input logic [31:0] x, input logic [31:0] y);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    p = {1'b1, x[22:0]} * {1'b1, y[22:0]};
    e = {2'b0, x[30:23]} + {2'b0, y[30:23]} - 10'd127;
    if (p[47]) begin m = p[46:24]; e = e + 10'd1; end
    else m = p[45:23];
    return {x[31] ^ y[31], e[7:0], m};
  endfunction

  // multiplier stub: answers stub_lat cycles after issue unless disabled
  logic        stub_en = 1'b1;
  int          stub_lat = 0;
  logic        stub_ready = 1'b0;
  logic [31:0] stub_result = '0;
  logic        man_ready = 1'b0;
  logic [31:0] man_result = '0;
  assign mul_ready  = stub_ready | man_ready;
  assign mul_result = man_ready ? man_result : stub_result;

  initial begin
    logic        pend;
    int          cnt;
    logic [31:0] op1, op2;
    pend = 1'b0; cnt = 0; op1 = '0; op2 = '0;
    forever begin
      @(negedge clk);
      stub_ready = 1'b0;
      if (!reset) pend = 1'b0;
      if (pend && cnt == 0) begin
        stub_ready  = 1'b1;
        stub_result = fp_mul_model(op1, op2);
        pend = 1'b0;
      end else if (pend) begin
        cnt--;
      end
      if (mul_valid && stub_en) begin
        pend = 1'b1; cnt = stub_lat; op1 = mul_din1; op2 = mul_din2;
      end
    end
  end

  // response monitor
  initial begin
    logic [35:0]   e;
    logic [NR-1:0] one;
    forever begin
      @(negedge clk);
      if (resp_valid != '0) begin
        resp_cyc = cyc;
        if (exp_q.size() == 0) begin
          unexp_cnt++;
          tests++; fails++;
          $display("FAIL unexpected_resp: resp_valid=0x%0h data=0x%0h (cycle %0d)", resp_valid, resp_data, cyc);
        end else begin
          e = exp_q.pop_front();
          one = '0;
          one[e[34:32]] = 1'b1;
          chk("resp_valid_onehot", 64'(resp_valid), 64'(one));
          chk("resp_data", 64'(resp_data), 64'(e[31:0]));
          chk("resp_err", 64'(resp_err), 64'(e[35]));
        end
      end
    end
  end

  // driver: raise a request; optionally expect a response for it
  task automatic post(input int id, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input logic err, input logic want_resp);
    logic [NR-1:0] one;
    one = '0;
    one[id] = 1'b1;
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
    req_valid[id] = 1'b1;
    acc_q.push_back({one, a, b});
    if (want_resp) exp_q.push_back({err, 3'(id), exp});
  endtask

  // wait for n accepts, checking each against the accept queue; drop served requests
  task automatic wait_accepts(input int n, input int budget);
    int got;
    logic mv_check;
    logic [67:0] e;
    got = 0;
    mv_check = 1'b0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (mv_check) begin
        chk("mul_valid_single_pulse", 64'(mul_valid), 64'd0);
        mv_check = 1'b0;
      end
      if (req_accept != '0) begin
        issue_cyc = cyc;
        e = acc_q.pop_front();
        chk("req_accept", 64'(req_accept), 64'(e[67:64]));
        chk("mul_valid_with_accept", 64'(mul_valid), 64'd1);
        chk("mul_din", {mul_din1, mul_din2}, e[63:0]);
        req_valid = req_valid & ~req_accept;
        mv_check = 1'b1;
        got++;
      end
    end
    if (got < n) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got %0d accepts expected %0d", got, n);
    end
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int u0;
    vecs[0] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000};  // 2*3=6
    vecs[1] = '{1, 32'h3FC00000, 32'h3FC00000, 32'h40100000};  // 1.5^2=2.25
    vecs[2] = '{3, 32'h3F800000, 32'h40800000, 32'h40800000};  // 1*4=4
    vecs[3] = '{2, 32'h40A00000, 32'h40000000, 32'h41200000};  // 5*2=10
    vecs[4] = '{1, 32'hC0000000, 32'h40400000, 32'hC0C00000};  // -2*3=-6
    vecs[5] = '{0, 32'h40400000, 32'h40400000, 32'h41100000};  // 3*3=9

    // reset
    #1 reset = 1'b0;
    #3;
    chk("reset_outputs", {req_accept, resp_valid, resp_err, mul_valid, busy, dbg_state}, 64'd0);
    chk("reset_data", {resp_data, mul_din1}, 64'd0);
    chk("reset_din2", 64'(mul_din2), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // table: one requester at a time, random multiplier latency
    for (int i = 0; i < 6; i++) begin
      stub_lat = $urandom_range(0, 5);
      post(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, 1'b1);
      wait_accepts(1, 20);
      drain(40);
      chk("resp_data_holds", 64'(resp_data), 64'(vecs[i].exp));
      chk("resp_strobe_cleared", {resp_valid, resp_err, busy}, 64'd0);
    end

    // all four valid straight after reset: order 0,1,2,3
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    stub_lat = 2;
    post(0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b1);
    post(1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b1);
    post(2, 32'h3F800000, 32'h40800000, 32'h40800000, 1'b0, 1'b1);
    post(3, 32'h40400000, 32'h40400000, 32'h41100000, 1'b0, 1'b1);
    wait_accepts(4, 100);
    drain(40);

    // grant to 2, then 0 and 3 together: pointer=3 so 3 goes first
    stub_lat = 1;
    post(2, 32'h40A00000, 32'h40000000, 32'h41200000, 1'b0, 1'b1);
    wait_accepts(1, 20);
    drain(40);
    post(3, 32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b1);
    post(0, 32'h3F800000, 32'h40800000, 32'h40800000, 1'b0, 1'b1);
    wait_accepts(2, 60);
    drain(40);

    // timeout: multiplier never answers
    stub_en = 1'b0;
    post(1, 32'h40000000, 32'h40400000, NAN, 1'b1, 1'b1);
    wait_accepts(1, 20);
    drain(TOUT + 20);
    chk("timeout_latency", 64'(resp_cyc - issue_cyc), 64'(TOUT + 2));
    // late completion pulse while idle must be ignored
    repeat (4) @(negedge clk);
    man_result = 32'h12345678;
    man_ready = 1'b1;
    @(negedge clk);
    man_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk("late_ready_no_resp", 64'(unexp_cnt), 64'd0);
    chk("late_ready_idle", 64'(busy), 64'd0);

    // ready arrives in the cycle where timer==TOUT-1: normal result wins
    post(2, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b1);
    wait_accepts(1, 20);
    repeat (TOUT) @(negedge clk);
    man_result = 32'h40C00000;
    man_ready = 1'b1;
    @(negedge clk);
    man_ready = 1'b0;
    drain(20);
    chk("tie_latency", 64'(resp_cyc - issue_cyc), 64'(TOUT + 2));

    // reset during WAIT_RES aborts the op; pointer returns to 0
    post(1, 32'h40400000, 32'h40400000, 32'h0, 1'b0, 1'b0);
    wait_accepts(1, 20);
    repeat (4) @(negedge clk);
    chk("abort_in_wait", 64'(dbg_state), 64'd2);
    #2 reset = 1'b0;
    #1;
    chk("abort_outputs", {req_accept, resp_valid, resp_err, mul_valid, busy, dbg_state}, 64'd0);
    chk("abort_data", {resp_data, mul_din1}, 64'd0);
    chk("abort_din2", 64'(mul_din2), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_resp", 64'(unexp_cnt), 64'd0);
    stub_en = 1'b1;
    u0 = $urandom_range(0, 3);
    stub_lat = u0;
    post(1, 32'h40400000, 32'h40400000, 32'h41100000, 1'b0, 1'b1);
    post(3, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b1);
    wait_accepts(2, 60);
    drain(40);
    chk("final_unexpected", 64'(unexp_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "global timeout");
  end
endmodule
